spi_master: RTL and testbench

SPI mode-0 master (CPOL=0, CPHA=0), MSB first, 8-bit frames. It is the initiator for the on-FPGA SPI slave and for external SPI peripherals.
- Accepts bytes from a valid/ready stream and serializes them on MOSI.
- Samples MISO and returns each received byte as a one-cycle pulse.
- Holds SSEL low across multi-byte bursts, which end at the byte marked tx_last.
- Guarantees SCK half-periods long enough for a slave that oversamples SCK/SSEL/MOSI with 2-3 stage synchronizers.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_master_if.sv | 29 ++
 rtl/spi_clk_gen.sv | 39 +++
 rtl/spi_master.sv | 182 ++++++++++++++++++
 tb/tb_spi_master.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and frame constants for the SPI master
// and the on-FPGA SPI slave.
package spi_pkg;

    localparam int SPI_BITS         = 8;
    localparam int SPI_MIN_HALF_DIV = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        NEXT,
        HOLD,
        GAP
    } spi_state_t;

endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: byte stream handshake, receive pulse and SPI pins of the
// master. The master modport is the RTL side; the slave modport is the
// side that feeds bytes in and plays the SPI peripheral.
interface spi_master_if;
    import spi_pkg::*;

    logic [SPI_BITS-1:0] tx_data;
    logic                tx_last;
    logic                tx_valid;
    logic                tx_ready;
    logic [SPI_BITS-1:0] rx_data;
    logic                rx_valid;
    logic                busy;
    logic                SCK;
    logic                MOSI;
    logic                MISO;
    logic                SSEL;

    modport master (
        input  tx_data, tx_last, tx_valid, MISO,
        output tx_ready, rx_data, rx_valid, busy, SCK, MOSI, SSEL
    );

    modport slave (
        output tx_data, tx_last, tx_valid, MISO,
        input  tx_ready, rx_data, rx_valid, busy, SCK, MOSI, SSEL
    );

endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period timer for the SPI master. Counts 0..HALF_DIV-1
// while enabled and flags the last cycle of each half-period; held at zero
// while disabled so every enabled stretch starts with a full half-period.
module spi_clk_gen #(
    parameter int HALF_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic half_tick_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       atEnd;

    assign atEnd       = (cnt_q == 8'(HALF_DIV - 1));
    assign half_tick_o = en_i && atEnd;

    // Next count: park at zero when disabled, wrap after the last cycle of a half-period
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || atEnd) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Half-period counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 (CPOL=0, CPHA=0) master, MSB first, 8-bit frames.
// Serializes bytes from a valid/ready stream onto MOSI, returns each byte
// sampled from MISO as a one-cycle rx_valid pulse, and keeps SSEL low across
// a burst until the byte flagged tx_last has been shifted.
module spi_master
    import spi_pkg::*;
#(
    parameter int HALF_DIV     = 8,
    parameter int SETUP_HALVES = 2,
    parameter int GAP_HALVES   = 2
) (
    input logic          clk,
    input logic          rst,
    spi_master_if.master bus
);

    if (HALF_DIV < SPI_MIN_HALF_DIV || HALF_DIV > 255) begin : gBadHalfDiv
        $error("spi_master: HALF_DIV must lie in 4..255");
    end
    if (SETUP_HALVES < 1 || SETUP_HALVES > 8) begin : gBadSetup
        $error("spi_master: SETUP_HALVES must lie in 1..8");
    end
    if (GAP_HALVES < 1 || GAP_HALVES > 8) begin : gBadGap
        $error("spi_master: GAP_HALVES must lie in 1..8");
    end

    spi_state_t          state_q;
    logic                launch_q;
    logic [2:0]          bitCnt_q;
    logic [SPI_BITS-1:0] txShift_q;
    logic [SPI_BITS-1:0] rxShift_q;
    logic                last_q;
    logic                sck_q;
    logic                ssel_q;
    logic                txReady_q;
    logic [SPI_BITS-1:0] rxData_q;
    logic                rxValid_q;
    logic                busy_q;
    logic                misoMeta_q;
    logic                misoSync_q;

    logic                clkEn;
    logic                halfTick;
    logic                handshake;

    // The timer idles in IDLE and NEXT, and for the launch cycle right after
    // a burst starts; that launch cycle gives MOSI one extra clk of setup.
    assign clkEn     = (state_q != IDLE) && (state_q != NEXT) && !launch_q;
    assign handshake = bus.tx_valid && txReady_q;

    spi_clk_gen #(
        .HALF_DIV(HALF_DIV)
    ) uClkGen (
        .clk        (clk),
        .rst        (rst),
        .en_i       (clkEn),
        .half_tick_o(halfTick)
    );

    assign bus.SCK      = sck_q;
    assign bus.MOSI     = txShift_q[SPI_BITS-1];
    assign bus.SSEL     = ssel_q;
    assign bus.tx_ready = txReady_q;
    assign bus.rx_data  = rxData_q;
    assign bus.rx_valid = rxValid_q;
    assign bus.busy     = busy_q;

    // Two-flop synchronizer for the asynchronous MISO input
    always_ff @(posedge clk) begin
        if (rst) begin
            misoMeta_q <= 1'b0;
            misoSync_q <= 1'b0;
        end else begin
            misoMeta_q <= bus.MISO;
            misoSync_q <= misoMeta_q;
        end
    end

    // Frame sequencer; MOSI is the MSB of the tx shift register, so clearing
    // the register drives MOSI low between bursts
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            launch_q  <= 1'b0;
            bitCnt_q  <= 3'd0;
            txShift_q <= '0;
            rxShift_q <= '0;
            last_q    <= 1'b0;
            sck_q     <= 1'b0;
            ssel_q    <= 1'b1;
            txReady_q <= 1'b0;
            rxData_q  <= '0;
            rxValid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rxValid_q <= 1'b0;
            launch_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    txReady_q <= 1'b1;
                    busy_q    <= 1'b0;
                    if (handshake) begin
                        txShift_q <= bus.tx_data;
                        last_q    <= bus.tx_last;
                        ssel_q    <= 1'b0;
                        bitCnt_q  <= 3'd0;
                        launch_q  <= 1'b1;
                        txReady_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (halfTick) begin
                        if (bitCnt_q == 3'(SETUP_HALVES - 1)) begin
                            bitCnt_q <= 3'd0;
                            state_q  <= SHIFT;
                        end else begin
                            bitCnt_q <= bitCnt_q + 3'd1;
                        end
                    end
                end
                SHIFT: begin
                    if (halfTick) begin
                        if (!sck_q) begin
                            sck_q     <= 1'b1;
                            rxShift_q <= {rxShift_q[SPI_BITS-2:0], misoSync_q};
                        end else begin
                            sck_q <= 1'b0;
                            if (bitCnt_q != 3'(SPI_BITS - 1)) begin
                                txShift_q <= {txShift_q[SPI_BITS-2:0], 1'b0};
                                bitCnt_q  <= bitCnt_q + 3'd1;
                            end else begin
                                rxData_q  <= rxShift_q;
                                rxValid_q <= 1'b1;
                                if (last_q) begin
                                    state_q <= HOLD;
                                end else begin
                                    txReady_q <= 1'b1;
                                    state_q   <= NEXT;
                                end
                            end
                        end
                    end
                end
                NEXT: begin
                    if (handshake) begin
                        txShift_q <= bus.tx_data;
                        last_q    <= bus.tx_last;
                        bitCnt_q  <= 3'd0;
                        txReady_q <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                HOLD: begin
                    if (halfTick) begin
                        ssel_q    <= 1'b1;
                        txShift_q <= '0;
                        bitCnt_q  <= 3'd0;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    if (halfTick) begin
                        if (bitCnt_q == 3'(GAP_HALVES - 1)) begin
                            bitCnt_q  <= 3'd0;
                            txReady_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            bitCnt_q <= bitCnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master with HALF_DIV=4,
// SETUP_HALVES=2, GAP_HALVES=2 and a mode-0 slave model on MISO.
module tb_spi_master;
    import spi_pkg::*;

    localparam int HD = 4;

    logic clk = 1'b0;
    logic rst;

    spi_master_if bus();

    spi_master #(
        .HALF_DIV    (HD),
        .SETUP_HALVES(2),
        .GAP_HALVES  (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] txByte;
        logic [7:0] respByte;
        int         lowCycles;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] resp [0:7];

    // Bus observers, written only by the monitor processes
    int         cyc = 0;
    int         riseCyc[$];
    logic       riseMosi[$];
    logic [7:0] rxQ[$];
    int         sselLow = 0;
    int         sselRises = 0;
    int         hsCnt = 0;
    int         gapCyc = 0;
    int         gapReadyBad = 0;
    int         highRun = 0;
    int         lastHighRun = 0;
    logic       prevSck = 1'b0;
    logic       prevSsel = 1'b1;

    // Clock cycle counter
    always @(posedge clk) cyc++;

    // Sample the bus in mid-cycle and log edges, pulses and handshakes
    always @(negedge clk) begin
        if (bus.SCK === 1'b1 && prevSck === 1'b0) begin
            riseCyc.push_back(cyc);
            riseMosi.push_back(bus.MOSI);
        end
        prevSck = bus.SCK;
        if (bus.rx_valid === 1'b1) rxQ.push_back(bus.rx_data);
        if (bus.SSEL === 1'b0) sselLow++;
        if (bus.SSEL === 1'b1 && prevSsel === 1'b0) sselRises++;
        prevSsel = bus.SSEL;
        if (bus.SSEL === 1'b1) begin
            highRun++;
        end else if (bus.SSEL === 1'b0) begin
            if (highRun > 0) lastHighRun = highRun;
            highRun = 0;
        end
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) hsCnt++;
        if (bus.busy === 1'b1 && bus.SSEL === 1'b1) begin
            gapCyc++;
            if (bus.tx_ready !== 1'b0) gapReadyBad++;
        end
    end

    // Mode-0 slave model: first bit ready at SSEL fall, next bit after each SCK fall
    int         slvBit = 0;
    int         respIdx = 0;
    logic [7:0] slvShift = 8'h00;
    always @(negedge bus.SCK or negedge bus.SSEL or posedge bus.SSEL) begin
        if (bus.SSEL === 1'b1) begin
            slvBit  = 0;
            respIdx = 0;
        end else if (bus.SSEL === 1'b0) begin
            if (slvBit == 0 || slvBit == 8) begin
                slvShift = (respIdx < 8) ? resp[respIdx] : 8'h00;
                respIdx++;
                bus.MISO = slvShift[7];
                slvBit   = 1;
            end else begin
                bus.MISO = slvShift[7 - slvBit];
                slvBit++;
            end
        end
    end

    // Absolute time limit for the whole run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] mosiByte(input int base);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b = {b[6:0], (base + i < riseMosi.size()) ? riseMosi[base + i] : 1'b0};
        end
        return b;
    endfunction

    // Offer one byte and wait for the master to take it; returns at posedge+1
    task automatic applyStimulus(input string name, input logic [7:0] data,
                                 input logic last, input logic keepValid);
        int got;
        bus.tx_data  = data;
        bus.tx_last  = last;
        bus.tx_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 2000 && got == 0; i++) begin
            if (bus.tx_ready === 1'b1) begin
                @(posedge clk);
                got = 1;
            end else begin
                @(negedge clk);
            end
        end
        #1;
        if (!keepValid) bus.tx_valid = 1'b0;
        checkOutput({name, " accepted"}, got, 1);
    endtask

    task automatic waitIdle(input string name);
        int done;
        done = 0;
        for (int i = 0; i < 3000 && done == 0; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) done = 1;
        end
        checkOutput({name, " returned idle"}, done, 1);
    endtask

    task automatic runFrame(input string name, input vec_t v);
        int bRise, bRx, bLow;
        bRise   = riseMosi.size();
        bRx     = rxQ.size();
        bLow    = sselLow;
        resp[0] = v.respByte;
        applyStimulus(name, v.txByte, 1'b1, 1'b0);
        waitIdle(name);
        checkOutput({name, " mosi byte"}, mosiByte(bRise), v.txByte);
        checkOutput({name, " sck rises"}, riseMosi.size() - bRise, 8);
        checkOutput({name, " rx pulses"}, rxQ.size() - bRx, 1);
        checkOutput({name, " rx data"}, (rxQ.size() > bRx) ? rxQ[bRx] : 0, v.respByte);
        checkOutput({name, " ssel low cycles"}, sselLow - bLow, v.lowCycles);
    endtask

    vec_t vecs[4];

    initial begin
        int bRise, bRx, bLow, bSr, bHs, bGap, bGapBad, badSpace, reached, stallBad, expSpace;

        vecs[0] = '{txByte: 8'hA5, respByte: 8'h3C, lowCycles: 77};
        vecs[1] = '{txByte: 8'h00, respByte: 8'hFF, lowCycles: 77};
        vecs[2] = '{txByte: 8'hFF, respByte: 8'h00, lowCycles: 77};
        vecs[3] = '{txByte: 8'h81, respByte: 8'h7E, lowCycles: 77};

        bus.tx_data  = 8'h00;
        bus.tx_last  = 1'b0;
        bus.tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) resp[i] = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        checkOutput("reset SCK", bus.SCK, 0);
        checkOutput("reset SSEL", bus.SSEL, 1);
        checkOutput("reset MOSI", bus.MOSI, 0);
        checkOutput("reset tx_ready", bus.tx_ready, 0);
        checkOutput("reset rx_valid", bus.rx_valid, 0);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset rx_data", bus.rx_data, 0);

        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle tx_ready", bus.tx_ready, 1);
        checkOutput("idle busy", bus.busy, 0);

        for (int k = 0; k < 4; k++) begin
            runFrame($sformatf("single%0d", k), vecs[k]);
        end

        // Back-to-back burst of three bytes with tx_valid held high
        resp[0] = 8'hC3;
        resp[1] = 8'h5A;
        resp[2] = 8'h01;
        bRise = riseMosi.size();
        bRx   = rxQ.size();
        bLow  = sselLow;
        bSr   = sselRises;
        applyStimulus("burst b0", 8'h05, 1'b0, 1'b1);
        applyStimulus("burst b1", 8'h03, 1'b0, 1'b1);
        applyStimulus("burst b2", 8'hFF, 1'b1, 1'b0);
        waitIdle("burst");
        checkOutput("burst sck rises", riseMosi.size() - bRise, 24);
        checkOutput("burst mosi b0", mosiByte(bRise), 8'h05);
        checkOutput("burst mosi b1", mosiByte(bRise + 8), 8'h03);
        checkOutput("burst mosi b2", mosiByte(bRise + 16), 8'hFF);
        checkOutput("burst rx pulses", rxQ.size() - bRx, 3);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("burst rx b%0d", k),
                        (rxQ.size() > bRx + k) ? rxQ[bRx + k] : 0, resp[k]);
        end
        checkOutput("burst ssel low cycles", sselLow - bLow, 207);
        checkOutput("burst ssel rises", sselRises - bSr, 1);
        badSpace = 0;
        for (int i = 1; i < 24; i++) begin
            expSpace = (i % 8 == 0) ? 9 : 8;
            if (bRise + i < riseCyc.size()) begin
                if (riseCyc[bRise + i] - riseCyc[bRise + i - 1] != expSpace) badSpace++;
            end else begin
                badSpace++;
            end
        end
        checkOutput("burst rise spacing errors", badSpace, 0);

        // Stalled burst: first byte not last, second byte offered 50 cycles later
        resp[0] = 8'hA4;
        resp[1] = 8'h4B;
        bRise = riseMosi.size();
        bRx   = rxQ.size();
        bSr   = sselRises;
        applyStimulus("stall b0", 8'h11, 1'b0, 1'b0);
        reached = 0;
        for (int i = 0; i < 500 && reached == 0; i++) begin
            @(negedge clk);
            if (bus.tx_ready === 1'b1 && bus.SSEL === 1'b0) reached = 1;
        end
        checkOutput("stall reached next", reached, 1);
        stallBad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.SSEL !== 1'b0 || bus.SCK !== 1'b0 || bus.tx_ready !== 1'b1) stallBad++;
        end
        checkOutput("stall hold errors", stallBad, 0);
        applyStimulus("stall b1", 8'h22, 1'b1, 1'b0);
        waitIdle("stall");
        checkOutput("stall sck rises", riseMosi.size() - bRise, 16);
        checkOutput("stall mosi b0", mosiByte(bRise), 8'h11);
        checkOutput("stall mosi b1", mosiByte(bRise + 8), 8'h22);
        checkOutput("stall rx pulses", rxQ.size() - bRx, 2);
        checkOutput("stall rx b0", (rxQ.size() > bRx) ? rxQ[bRx] : 0, 8'hA4);
        checkOutput("stall rx b1", (rxQ.size() > bRx + 1) ? rxQ[bRx + 1] : 0, 8'h4B);
        checkOutput("stall ssel rises", sselRises - bSr, 1);

        // Reset after the third rising edge of a byte
        resp[0] = 8'hE1;
        bRise = riseMosi.size();
        bRx   = rxQ.size();
        applyStimulus("rstmid", 8'hC7, 1'b1, 1'b0);
        reached = 0;
        for (int i = 0; i < 500 && reached == 0; i++) begin
            @(negedge clk);
            if (riseMosi.size() - bRise >= 3) reached = 1;
        end
        checkOutput("rstmid reached third rise", reached, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid SSEL", bus.SSEL, 1);
        checkOutput("rstmid SCK", bus.SCK, 0);
        checkOutput("rstmid MOSI", bus.MOSI, 0);
        checkOutput("rstmid busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstmid rx pulses", rxQ.size() - bRx, 0);
        checkOutput("rstmid sck rises", riseMosi.size() - bRise, 3);
        runFrame("after reset", '{txByte: 8'h5A, respByte: 8'h96, lowCycles: 77});

        // Two single-byte frames with tx_valid held high across the gap
        resp[0] = 8'h69;
        bRise   = riseMosi.size();
        bRx     = rxQ.size();
        bHs     = hsCnt;
        bGap    = gapCyc;
        bGapBad = gapReadyBad;
        applyStimulus("gap f0", 8'h3A, 1'b1, 1'b1);
        applyStimulus("gap f1", 8'h6B, 1'b1, 1'b0);
        waitIdle("gap");
        checkOutput("gap sck rises", riseMosi.size() - bRise, 16);
        checkOutput("gap mosi f0", mosiByte(bRise), 8'h3A);
        checkOutput("gap mosi f1", mosiByte(bRise + 8), 8'h6B);
        checkOutput("gap rx pulses", rxQ.size() - bRx, 2);
        checkOutput("gap handshakes", hsCnt - bHs, 2);
        checkOutput("gap state cycles", gapCyc - bGap, 16);
        checkOutput("gap tx_ready high in gap", gapReadyBad - bGapBad, 0);
        checkOutput("gap ssel high at least 8", (lastHighRun >= 8) ? 1 : 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
